// File: rtl/mem_bus_router.sv
// mem_bus_router: routes one CPU valid/ready request at a time to the BRAM, UART or LED target.
// Latency: target valid rises the cycle after acceptance; cpu_ready pulses the cycle after the target's ready (unmapped: the cycle after acceptance).
// Backpressure: one transaction in flight; cpu_valid is sampled only in IDLE; a target stalls the CPU for as long as it holds its ready low.
//
// Ports:
//   clk, reset_n                      clock and synchronous active-low reset
//   cpu_valid/ready/addr/wdata/wstrb  CPU request channel (wstrb == 0 means read)
//   cpu_rdata                         read data, held until the next response
//   slv_addr/wdata/wstrb              request fields shared by all targets
//   {bram,uart,led}_valid/ready/rdata per-target handshake and read data
//   bus_err                           one-cycle pulse on an unmapped or timed-out access
//
// Optional feature: define BUS_TIMEOUT_EN to abort a target access after
// TIMEOUT_CYCLES cycles of target valid with no ready.  With the macro
// undefined the router waits indefinitely and carries no counter.

module mem_bus_router #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,

  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wstrb,

  output logic        bram_valid,
  input  logic        bram_ready,
  input  logic [31:0] bram_rdata,

  output logic        uart_valid,
  input  logic        uart_ready,
  input  logic [31:0] uart_rdata,

  output logic        led_valid,
  input  logic        led_ready,
  input  logic [31:0] led_rdata,

  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_BRAM = 2'd1,
    TGT_UART = 2'd2,
    TGT_LED  = 2'd3
  } tgt_t;

  // The counter only needs to reach TIMEOUT_CYCLES-1, so below 2 the
  // timeout would be meaningless.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("mem_bus_router: TIMEOUT_CYCLES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,      state_d;
  tgt_t        tgt_q,        tgt_d;
  logic [31:0] slv_addr_q,   slv_addr_d;
  logic [31:0] slv_wdata_q,  slv_wdata_d;
  logic [3:0]  slv_wstrb_q,  slv_wstrb_d;
  logic        bram_valid_q, bram_valid_d;
  logic        uart_valid_q, uart_valid_d;
  logic        led_valid_q,  led_valid_d;
  logic        cpu_ready_q,  cpu_ready_d;
  logic        bus_err_q,    bus_err_d;
  logic [31:0] cpu_rdata_q,  cpu_rdata_d;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Address decode of the incoming CPU address
  // ---------------------------------------------------------------------------
  function automatic tgt_t decode(input logic [31:0] addr);
    tgt_t t;
    t = TGT_NONE;
    if (addr[31:13] == 19'h0) begin
      t = TGT_BRAM;
    end else if (addr[31:12] == 20'hF0000) begin
      t = TGT_UART;
    end else if (addr[31:12] == 20'hF0001) begin
      t = TGT_LED;
    end
    return t;
  endfunction

  tgt_t cpu_tgt;
  assign cpu_tgt = decode(cpu_addr);

  // Ready/rdata of the latched target only; every other ready is ignored.
  logic        sel_ready;
  logic [31:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    case (tgt_q)
      TGT_BRAM: begin
        sel_ready = bram_ready;
        sel_rdata = bram_rdata;
      end
      TGT_UART: begin
        sel_ready = uart_ready;
        sel_rdata = uart_rdata;
      end
      TGT_LED: begin
        sel_ready = led_ready;
        sel_rdata = led_rdata;
      end
      default: begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
      end
    endcase
  end

  logic is_read_q;
  assign is_read_q = (slv_wstrb_q == 4'b0000);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    slv_addr_d   = slv_addr_q;
    slv_wdata_d  = slv_wdata_q;
    slv_wstrb_d  = slv_wstrb_q;
    bram_valid_d = bram_valid_q;
    uart_valid_d = uart_valid_q;
    led_valid_d  = led_valid_q;
    cpu_rdata_d  = cpu_rdata_q;
    // cpu_ready and bus_err are single-cycle pulses by construction.
    cpu_ready_d  = 1'b0;
    bus_err_d    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          slv_addr_d  = cpu_addr;
          slv_wdata_d = cpu_wdata;
          slv_wstrb_d = cpu_wstrb;
          tgt_d       = cpu_tgt;
`ifdef BUS_TIMEOUT_EN
          cnt_d       = '0;
`endif
          if (cpu_tgt == TGT_NONE) begin
            // Unmapped: answer immediately with an error, never touch a target.
            state_d     = RESP;
            cpu_ready_d = 1'b1;
            bus_err_d   = 1'b1;
            cpu_rdata_d = 32'h0;
          end else begin
            state_d      = ACCESS;
            bram_valid_d = (cpu_tgt == TGT_BRAM);
            uart_valid_d = (cpu_tgt == TGT_UART);
            led_valid_d  = (cpu_tgt == TGT_LED);
          end
        end
      end

      ACCESS: begin
        if (sel_ready) begin
          state_d      = RESP;
          bram_valid_d = 1'b0;
          uart_valid_d = 1'b0;
          led_valid_d  = 1'b0;
          cpu_ready_d  = 1'b1;
          cpu_rdata_d  = is_read_q ? sel_rdata : 32'h0;
        end
`ifdef BUS_TIMEOUT_EN
        // cnt_q counts completed cycles of target valid without ready; the
        // edge that would complete the TIMEOUT_CYCLES-th such cycle aborts.
        else if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          bram_valid_d = 1'b0;
          uart_valid_d = 1'b0;
          led_valid_d  = 1'b0;
          cpu_ready_d  = 1'b1;
          bus_err_d    = 1'b1;
          cpu_rdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      RESP: begin
        // cpu_ready is high for this one cycle; a new request is only
        // sampled once back in IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d      = IDLE;
        bram_valid_d = 1'b0;
        uart_valid_d = 1'b0;
        led_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tgt_q        <= TGT_NONE;
      slv_addr_q   <= 32'h0;
      slv_wdata_q  <= 32'h0;
      slv_wstrb_q  <= 4'h0;
      bram_valid_q <= 1'b0;
      uart_valid_q <= 1'b0;
      led_valid_q  <= 1'b0;
      cpu_ready_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      cpu_rdata_q  <= 32'h0;
`ifdef BUS_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      slv_addr_q   <= slv_addr_d;
      slv_wdata_q  <= slv_wdata_d;
      slv_wstrb_q  <= slv_wstrb_d;
      bram_valid_q <= bram_valid_d;
      uart_valid_q <= uart_valid_d;
      led_valid_q  <= led_valid_d;
      cpu_ready_q  <= cpu_ready_d;
      bus_err_q    <= bus_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from flops
  // ---------------------------------------------------------------------------
  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign bus_err    = bus_err_q;
  assign slv_addr   = slv_addr_q;
  assign slv_wdata  = slv_wdata_q;
  assign slv_wstrb  = slv_wstrb_q;
  assign bram_valid = bram_valid_q;
  assign uart_valid = uart_valid_q;
  assign led_valid  = led_valid_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// tb_mem_bus_router: randomized transactions checked against a transaction-level model.
// Latency: one model step per CPU transaction; outputs sampled on the falling edge.
// Backpressure: target readys are driven with per-transaction latencies and random noise on unselected targets.

module tb_mem_bus_router;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wstrb;
  logic        bram_valid, bram_ready;
  logic [31:0] bram_rdata;
  logic        uart_valid, uart_ready;
  logic [31:0] uart_rdata;
  logic        led_valid, led_ready;
  logic [31:0] led_rdata;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_router #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_rdata  (cpu_rdata),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_wstrb  (slv_wstrb),
    .bram_valid (bram_valid),
    .bram_ready (bram_ready),
    .bram_rdata (bram_rdata),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready),
    .uart_rdata (uart_rdata),
    .led_valid  (led_valid),
    .led_ready  (led_ready),
    .led_rdata  (led_rdata),
    .bus_err    (bus_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory map as address ranges: 0 = unmapped, 1 = BRAM, 2 = UART, 3 = LED.
  function automatic int region(input logic [31:0] a);
    if (a < 32'h0000_2000) return 1;
    if (a >= 32'hF000_0000 && a < 32'hF000_1000) return 2;
    if (a >= 32'hF000_1000 && a < 32'hF000_2000) return 3;
    return 0;
  endfunction

  // Expected {bram,uart,led}_valid for a region (0 means none).
  function automatic logic [31:0] valid_vec(input int r);
    logic [31:0] v;
    v = 32'h0;
    if (r == 1) v = 32'h4;
    if (r == 2) v = 32'h2;
    if (r == 3) v = 32'h1;
    return v;
  endfunction

  logic [31:0] model_rdata;

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_readys(input int sel, input bit sel_rdy, input bit force_bram);
    bram_ready = (sel == 1) ? sel_rdy : (force_bram || ($urandom_range(0, 1) == 1));
    uart_ready = (sel == 2) ? sel_rdy : ($urandom_range(0, 1) == 1);
    led_ready  = (sel == 3) ? sel_rdy : ($urandom_range(0, 1) == 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valids"}, {29'h0, bram_valid, uart_valid, led_valid}, 32'h0);
    check_eq({tag, "_cpu_ready"}, {31'h0, cpu_ready}, 32'h0);
    check_eq({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
    check_eq({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    check_eq({tag, "_slv_addr"}, slv_addr, 32'h0);
    check_eq({tag, "_slv_wdata"}, slv_wdata, 32'h0);
    check_eq({tag, "_slv_wstrb"}, {28'h0, slv_wstrb}, 32'h0);
  endtask

  // Starts at a falling edge with the router in IDLE (from_resp=0) or in its
  // RESP cycle (from_resp=1); ends at the falling edge inside the RESP cycle.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int lat,
                         input bit from_resp, input bit force_bram,
                         input logic [31:0] rd);
    int          r;
    int          vcyc;
    bit          tmo;
    logic [31:0] exp_rd;
    r    = region(addr);
    vcyc = lat;
    tmo  = 1'b0;
`ifdef BUS_TIMEOUT_EN
    if (r != 0 && lat > TO) begin
      tmo  = 1'b1;
      vcyc = TO;
    end
`endif
    cpu_valid  = 1'b1;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    cpu_wstrb  = wstrb;
    bram_rdata = (r == 1) ? rd : (rd ^ ($urandom | 32'h1));
    uart_rdata = (r == 2) ? rd : (rd ^ ($urandom | 32'h2));
    led_rdata  = (r == 3) ? rd : (rd ^ ($urandom | 32'h4));
    set_readys(r, 1'b0, force_bram);
    if (from_resp) begin
      // Request held through RESP must not be taken until the IDLE cycle.
      next_cycle();
      check_eq("resp_pulse_width", {31'h0, cpu_ready}, 32'h0);
      check_eq("no_accept_in_resp", {29'h0, bram_valid, uart_valid, led_valid}, 32'h0);
      set_readys(r, 1'b0, force_bram);
    end
    check_eq("rdata_hold", cpu_rdata, model_rdata);
    next_cycle();
    if (r == 0) begin
      check_eq("unmapped_ready", {31'h0, cpu_ready}, 32'h1);
      check_eq("unmapped_err", {31'h0, bus_err}, 32'h1);
      check_eq("unmapped_rdata", cpu_rdata, 32'h0);
      check_eq("unmapped_valids", {29'h0, bram_valid, uart_valid, led_valid}, 32'h0);
      check_eq("unmapped_slv_addr", slv_addr, addr);
      model_rdata = 32'h0;
    end else begin
      for (int c = 1; c <= vcyc; c++) begin
        check_eq("access_valids", {29'h0, bram_valid, uart_valid, led_valid}, valid_vec(r));
        check_eq("access_no_ready", {30'h0, cpu_ready, bus_err}, 32'h0);
        if (c == 1 || c == vcyc) begin
          check_eq("slv_addr", slv_addr, addr);
          check_eq("slv_wdata", slv_wdata, wdata);
          check_eq("slv_wstrb", {28'h0, slv_wstrb}, {28'h0, wstrb});
        end
        set_readys(r, (!tmo && c == vcyc), force_bram);
        next_cycle();
      end
      exp_rd = (tmo || wstrb != 4'b0000) ? 32'h0 : rd;
      check_eq("resp_ready", {31'h0, cpu_ready}, 32'h1);
      check_eq("resp_err", {31'h0, bus_err}, {31'h0, tmo});
      check_eq("resp_rdata", cpu_rdata, exp_rd);
      check_eq("resp_valids", {29'h0, bram_valid, uart_valid, led_valid}, 32'h0);
      model_rdata = exp_rd;
    end
    cpu_valid = 1'b0;
    set_readys(0, 1'b0, force_bram);
  endtask

  // Leaves RESP and idles a few cycles with noisy readys; router must stay quiet.
  task automatic idle_gap(input int n);
    next_cycle();
    check_eq("gap_cpu_ready", {31'h0, cpu_ready}, 32'h0);
    for (int i = 0; i < n; i++) begin
      set_readys(0, 1'b0, 1'b0);
      next_cycle();
      check_eq("gap_quiet", {27'h0, bram_valid, uart_valid, led_valid, cpu_ready, bus_err}, 32'h0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int cls;
    cls = $urandom_range(0, 3);
    case (cls)
      0:       return $urandom_range(32'h1FFF, 0);
      1:       return 32'hF000_0000 | ($urandom & 32'hFFF);
      2:       return 32'hF000_1000 | ($urandom & 32'hFFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    cpu_valid  = 1'b1;
    cpu_addr   = 32'h0000_0100;
    cpu_wdata  = 32'hA5A5_A5A5;
    cpu_wstrb  = 4'h0;
    bram_rdata = 32'h0;
    uart_rdata = 32'h0;
    led_rdata  = 32'h0;
    bram_ready = 1'b1;
    uart_ready = 1'b1;
    led_ready  = 1'b1;
    model_rdata = 32'h0;
    @(negedge clk);
    next_cycle();
    next_cycle();
    check_all_zero("reset");
    cpu_valid = 1'b0;
    reset_n   = 1'b1;

    // Directed cases.
    run_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'b0000, 3, 1'b0, 1'b0, 32'h1234_5678);
    run_txn(32'hF000_1000, 32'h0000_0037, 4'b1111, 2, 1'b1, 1'b0, 32'hCAFE_0001);
    run_txn(32'h8000_0000, 32'h0,         4'b0000, 1, 1'b1, 1'b0, 32'h0BAD_0BAD);
    run_txn(32'hF000_0004, 32'h0,         4'b0000, 5, 1'b1, 1'b1, 32'h5555_AAAA);
    idle_gap(2);
    // Decode boundaries and minimum latency.
    run_txn(32'h0000_1FFC, 32'h1,  4'b0000, 1, 1'b0, 1'b0, 32'h1111_2222);
    run_txn(32'h0000_2000, 32'h2,  4'b0000, 1, 1'b1, 1'b0, 32'h3333_4444);
    run_txn(32'hEFFF_FFFC, 32'h3,  4'b0011, 1, 1'b1, 1'b0, 32'h5555_6666);
    run_txn(32'hF000_0FFC, 32'h4,  4'b0000, 1, 1'b1, 1'b0, 32'h7777_8888);
    run_txn(32'hF000_1FFC, 32'h5,  4'b0000, 2, 1'b1, 1'b0, 32'h9999_AAAA);
    run_txn(32'hF000_2000, 32'h6,  4'b0000, 1, 1'b1, 1'b0, 32'hBBBB_CCCC);

    // Randomized traffic: back-to-back or with idle gaps.
    for (int t = 0; t < 150; t++) begin
      logic [3:0] ws;
      bit         b2b;
      ws  = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
      b2b = ($urandom_range(0, 2) != 0);
      if (!b2b) idle_gap($urandom_range(0, 3));
      run_txn(rand_addr(), $urandom, ws, $urandom_range(1, 8), b2b, 1'b0, $urandom);
    end

`ifdef BUS_TIMEOUT_EN
    run_txn(32'hF000_0008, 32'h0, 4'b0000, 40, 1'b1, 1'b0, 32'h1357_9BDF);
    run_txn(32'h0000_0040, 32'h9, 4'b1111, 40, 1'b1, 1'b0, 32'h2468_ACE0);
    run_txn(32'h0000_0044, 32'h0, 4'b0000, TO, 1'b1, 1'b0, 32'h0F0F_0F0F);
`endif

    // Reset in the middle of an access aborts it with no response.
    idle_gap(1);
    cpu_valid = 1'b1;
    cpu_addr  = 32'h0000_0080;
    cpu_wdata = 32'h1;
    cpu_wstrb = 4'b0000;
    set_readys(1, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    check_eq("pre_reset_valid", {29'h0, bram_valid, uart_valid, led_valid}, 32'h4);
    reset_n   = 1'b0;
    cpu_valid = 1'b0;
    next_cycle();
    check_all_zero("mid_access_reset");
    reset_n    = 1'b1;
    bram_ready = 1'b1;
    uart_ready = 1'b1;
    led_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_eq("aborted_no_resp", {27'h0, bram_valid, uart_valid, led_valid, cpu_ready, bus_err}, 32'h0);
    end
    model_rdata = 32'h0;
    run_txn(32'hF000_0010, 32'h0, 4'b0000, 2, 1'b0, 1'b0, 32'hFEED_F00D);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
